// File: rtl/studio2_beeper.sv
// studio2_beeper: turns the CDP1802 Q pin (Studio II beeper enable) into a
// signed 16-bit PCM square tone at a fixed pitch, sampled every SAMPLE_DIV
// clocks and shaped by an envelope so Q edges do not click.
// Build option: define STUDIO2_BEEPER_RAMP_EN for the attack/release ramp;
// without it the tone is hard-keyed (IDLE <-> SUSTAIN only).
module studio2_beeper #(
   parameter int unsigned HALF_PERIOD = 22579,
   parameter int unsigned SAMPLE_DIV  = 588,
   parameter logic [15:0] AMPLITUDE   = 16'h3FFF,
   parameter logic [15:0] RAMP_STEP   = 16'h0100
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               q_in,
   input  logic               mute,
   output logic signed [15:0] audio,
   output logic               sample_strobe,
   output logic               active
);

   localparam int unsigned DIV_W  = (SAMPLE_DIV  > 1) ? $clog2(SAMPLE_DIV)  : 1;
   localparam int unsigned TONE_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(HALF_PERIOD - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ATTACK,
      S_SUSTAIN,
      S_RELEASE
   } state_t;

   // Elaboration-time guards on the parameter ranges the logic relies on
   if (HALF_PERIOD < 2) begin : g_chk_half_period
      $error("studio2_beeper: HALF_PERIOD must be >= 2");
   end
   if (SAMPLE_DIV < 2) begin : g_chk_sample_div
      $error("studio2_beeper: SAMPLE_DIV must be >= 2");
   end
   if (AMPLITUDE > 16'h7FFF) begin : g_chk_amplitude
      $error("studio2_beeper: AMPLITUDE must be <= 16'h7FFF");
   end
   if (RAMP_STEP == 16'h0000) begin : g_chk_ramp_step
      $error("studio2_beeper: RAMP_STEP must be > 0");
   end

   logic [DIV_W-1:0]   r_div;
   logic               r_q;
   state_t             r_state;
   logic [15:0]        r_env;
   logic               r_phase;
   logic [TONE_W-1:0]  r_tone_cnt;
   logic signed [15:0] r_audio;
   logic               r_active;

   logic               w_strobe;
   logic [15:0]        w_env_next;
   state_t             w_state_next;

   assign w_strobe      = (r_div == DIV_LAST);
   assign sample_strobe = w_strobe;
   assign audio         = r_audio;
   assign active        = r_active;

`ifdef STUDIO2_BEEPER_RAMP_EN
   logic [16:0] w_env_up;
   logic [16:0] w_env_dn;
   logic [15:0] w_env_up_sat;
   logic [15:0] w_env_dn_sat;

   // The extra bit catches overshoot above AMPLITUDE and borrow below zero,
   // so the envelope saturates instead of wrapping.
   assign w_env_up     = {1'b0, r_env} + {1'b0, RAMP_STEP};
   assign w_env_dn     = {1'b0, r_env} - {1'b0, RAMP_STEP};
   assign w_env_up_sat = (w_env_up > {1'b0, AMPLITUDE}) ? AMPLITUDE : w_env_up[15:0];
   assign w_env_dn_sat = w_env_dn[16] ? 16'h0000 : w_env_dn[15:0];
`endif

   // Free-running sample divider: 0 .. SAMPLE_DIV-1, strobe on the last count
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= '0;
      end else if (w_strobe) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   // Single register stage on Q; every edge decision below looks at r_q
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= 1'b0;
      end else begin
         r_q <= q_in;
      end
   end

   // Envelope value the current state would apply on a strobe, and next state.
   // A Q change always wins over a same-cycle saturation transition.
   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_env_next   = 16'h0000;
      w_state_next = r_state;
      case (r_state)
`ifdef STUDIO2_BEEPER_RAMP_EN
         S_IDLE: begin
            if (r_q) w_state_next = S_ATTACK;
         end
         S_ATTACK: begin
            w_env_next = w_env_up_sat;
            if (!r_q) begin
               w_state_next = S_RELEASE;
            end else if (w_strobe && (w_env_up_sat == AMPLITUDE)) begin
               w_state_next = S_SUSTAIN;
            end
         end
         S_SUSTAIN: begin
            w_env_next = AMPLITUDE;
            if (!r_q) w_state_next = S_RELEASE;
         end
         S_RELEASE: begin
            w_env_next = w_env_dn_sat;
            if (r_q) begin
               w_state_next = S_ATTACK;
            end else if (w_strobe && (w_env_dn_sat == 16'h0000)) begin
               w_state_next = S_IDLE;
            end
         end
`else
         S_IDLE: begin
            if (r_q) w_state_next = S_SUSTAIN;
         end
         S_SUSTAIN: begin
            w_env_next = AMPLITUDE;
            if (!r_q) w_state_next = S_IDLE;
         end
`endif
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Envelope FSM, tone generator and registered PCM output
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_active   <= 1'b0;
         r_env      <= 16'h0000;
         r_phase    <= 1'b0;
         r_tone_cnt <= '0;
         r_audio    <= '0;
      end else begin
         // Tone runs only while sounding; a fresh start begins on the positive half.
         if (r_state == S_IDLE) begin
            if (r_q) begin
               r_tone_cnt <= '0;
               r_phase    <= 1'b0;
            end
         end else if (r_tone_cnt == TONE_LAST) begin
            r_tone_cnt <= '0;
            r_phase    <= ~r_phase;
         end else begin
            r_tone_cnt <= r_tone_cnt + TONE_W'(1);
         end

         // Envelope and audio only move on the sample strobe, using the old state's step.
         if (w_strobe) begin
            r_env   <= w_env_next;
            r_audio <= mute    ? 16'sh0000 :
                       r_phase ? (16'h0000 - w_env_next) : w_env_next;
         end

         r_state  <= w_state_next;
         r_active <= (w_state_next != S_IDLE);
      end
   end

endmodule

// File: tb/tb_studio2_beeper.sv
// Testbench for studio2_beeper: a cycle-level behavioural model (envelope as
// an integer that saturates, tone phase from the count of sounding cycles)
// checked against the DUT every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_studio2_beeper;

   localparam int unsigned HP   = 10;
   localparam int unsigned SD   = 4;
   localparam int          AMP  = 'h3000;
   localparam int          STEP = 'h1000;
`ifdef STUDIO2_BEEPER_RAMP_EN
   localparam bit          RAMP = 1'b1;
`else
   localparam bit          RAMP = 1'b0;
`endif
   // Hard-keyed build: one "step" jumps straight to full scale or to zero.
   localparam int          MSTEP = RAMP ? STEP : AMP;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        q_in;
   logic        mute;
   logic [15:0] audio;
   logic        sample_strobe;
   logic        active;

   int n_checks = 0;
   int n_errors = 0;
   bit armed    = 1'b0;

   studio2_beeper #(
      .HALF_PERIOD(HP),
      .SAMPLE_DIV (SD),
      .AMPLITUDE  (16'h3000),
      .RAMP_STEP  (16'h1000)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .q_in         (q_in),
      .mute         (mute),
      .audio        (audio),
      .sample_strobe(sample_strobe),
      .active       (active)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int          k;     // clock edges since reset release
      bit          qr;    // Q as seen one clock late
      bit          act;   // sounding (envelope not idle)
      bit          up;    // envelope heading up (Q was high last cycle)
      int          env;
      int          age;   // sounding cycles since the tone was (re)started
      logic [15:0] aud;
   } model_t;

   function automatic model_t model_step(input model_t m, input bit q, input bit mu);
      model_t n;
      bit     strobe;
      bit     phase;
      int     env_new;
      n       = m;
      strobe  = ((m.k % SD) == SD - 1);
      phase   = (((m.age / HP) % 2) == 1);
      env_new = m.env;
      n.k     = m.k + 1;
      n.qr    = q;
      if (!m.act) begin
         if (m.qr) n.age = 0;
      end else begin
         n.age = m.age + 1;
      end
      if (strobe) begin
         if (!m.act)     env_new = 0;
         else if (m.up)  env_new = (m.env + MSTEP > AMP) ? AMP : m.env + MSTEP;
         else            env_new = (m.env - MSTEP < 0)   ? 0   : m.env - MSTEP;
         n.env = env_new;
         n.aud = mu ? 16'h0000 : (phase ? 16'(-env_new) : 16'(env_new));
      end
      if (!m.act) begin
         n.act = m.qr;
         n.up  = 1'b1;
      end else if (RAMP) begin
         n.act = !(strobe && !m.up && (env_new == 0) && !m.qr);
         n.up  = m.qr;
      end else begin
         n.act = m.qr;
         n.up  = 1'b1;
      end
      return n;
   endfunction

   model_t m;

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) m <= '{k: 0, qr: 1'b0, act: 1'b0, up: 1'b1, env: 0, age: 0, aud: 16'h0000};
      else          m <= model_step(m, q_in, mute);
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk_sys) begin
      if (armed) begin
         check("model_audio",  audio,         m.aud);
         check("model_strobe", sample_strobe, ((m.k % SD) == SD - 1));
         check("model_active", active,        m.act);
      end
   end

   // Wait for the next strobe (bounded), then read the sample it produced.
   task automatic next_sample(output logic [15:0] a);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4 * SD && !seen; i++) begin
         @(negedge clk_sys);
         seen = sample_strobe;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL strobe_timeout: no sample_strobe within %0d cycles", 4 * SD);
      end
      @(posedge clk_sys);
      #2;
      a = audio;
   endtask

   // Safety net: the run always reaches its summary.
   initial begin
      #100000;
      n_errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   logic [15:0] s;
   int          strobes;
   bit          noisy;
   int          edges;
   bit          seen_restart;

   initial begin
      reset_n = 1'b1;
      q_in    = 1'b0;
      mute    = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      check("reset_audio",  audio,         16'h0000);
      check("reset_strobe", sample_strobe, 1'b0);
      check("reset_active", active,        1'b0);
      repeat (2) @(posedge clk_sys);
      #2;
      reset_n = 1'b1;
      armed   = 1'b1;

      // Silence: q low for 100 cycles
      strobes = 0;
      noisy   = 1'b0;
      repeat (100) begin
         @(negedge clk_sys);
         if (sample_strobe) strobes++;
         if (audio != 16'h0000 || active) noisy = 1'b1;
      end
      check("idle_strobe_count", strobes, 25);
      check("idle_silent",       noisy,   1'b0);

      next_sample(s);              // align just after a strobe
      q_in = 1'b1;
`ifdef STUDIO2_BEEPER_RAMP_EN
      // Attack build-up, then the square toggling every HALF_PERIOD cycles
      next_sample(s); check("attack_1",   s, 16'h1000);
      next_sample(s); check("attack_2",   s, 16'h2000);
      next_sample(s); check("attack_3",   s, 16'h3000);
      next_sample(s); check("sustain_neg", s, 16'hD000);
      next_sample(s); check("sustain_neg2", s, 16'hD000);
      next_sample(s); check("sustain_pos", s, 16'h3000);
      // Release from sustain
      q_in = 1'b0;
      next_sample(s); check("release_1", s, 16'h2000);
      next_sample(s); check("release_2", s, 16'h1000);
      check("release_active_mid", active, 1'b1);
      next_sample(s); check("release_3", s, 16'h0000);
      check("release_active_end", active, 1'b0);
      // Re-attack, one-strobe Q dropout at env 0x2000, phase continues
      q_in = 1'b1;
      next_sample(s); check("reattack_1", s, 16'h1000);
      next_sample(s); check("reattack_2", s, 16'h2000);
      q_in = 1'b0;
      next_sample(s); check("dropout_down", s, 16'h1000);
      q_in = 1'b1;
      next_sample(s); check("dropout_climb_phase", s, 16'hE000);
      next_sample(s); check("dropout_full", s, 16'hD000);
`else
      // Hard-keyed: full scale on the first strobe, zero on the first after Q drops
      next_sample(s); check("key_on_1", s, 16'h3000);
      next_sample(s); check("key_on_2", s, 16'h3000);
      next_sample(s); check("key_on_3", s, 16'h3000);
      next_sample(s); check("key_on_neg", s, 16'hD000);
      q_in = 1'b0;
      next_sample(s); check("key_off", s, 16'h0000);
      check("key_off_active", active, 1'b0);
      q_in = 1'b1;
      next_sample(s); check("key_on_again", s, 16'h3000);
`endif

      // Mute in sustain: silent output, state untouched
      mute = 1'b1;
      next_sample(s); check("mute_zero", s, 16'h0000);
      check("mute_active", active, 1'b1);
      mute = 1'b0;
      next_sample(s); check("unmute_level", s, 16'h3000);

      // Asynchronous reset mid-tone
      reset_n = 1'b0;
      #1;
      check("async_reset_audio",  audio,         16'h0000);
      check("async_reset_active", active,        1'b0);
      check("async_reset_strobe", sample_strobe, 1'b0);
      repeat (2) @(posedge clk_sys);
      #2;
      reset_n      = 1'b1;
      edges        = 0;
      seen_restart = 1'b0;
      for (int i = 0; i < 4 * SD && !seen_restart; i++) begin
         @(posedge clk_sys);
         edges++;
         @(negedge clk_sys);
         seen_restart = sample_strobe;
      end
      check("restart_strobe_seen",  seen_restart, 1'b1);
      check("restart_strobe_edges", edges,        SD - 1);

      repeat (8) @(posedge clk_sys);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
